// File: rtl/sprite_draw_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_draw_scheduler_if
// Brief    : Command-push, frame-control and renderer signals for the
//            sprite draw scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface sprite_draw_scheduler_if #(
    parameter int CORDW  = 10,
    parameter int IDW    = 5,
    parameter int SCALEW = 8,
    parameter int DEPTH  = 8
);
    localparam int CNTW = $clog2(DEPTH) + 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CORDW-1:0]  cmd_sx;
    logic [CORDW-1:0]  cmd_sy;
    logic [IDW-1:0]    cmd_id;
    logic [SCALEW-1:0] cmd_scale;
    logic              frame_start;
    logic              frame_done;
    logic              busy;
    logic [CNTW-1:0]   queue_count;
    logic              timeout_err;
    logic              r_rst;
    logic              r_enable;
    logic [CORDW-1:0]  r_sx;
    logic [CORDW-1:0]  r_sy;
    logic [SCALEW-1:0] r_scale;
    logic [IDW-1:0]    r_id;
    logic              r_finished;

    modport master (
        output cmd_valid, cmd_sx, cmd_sy, cmd_id, cmd_scale, frame_start, r_finished,
        input  cmd_ready, frame_done, busy, queue_count, timeout_err,
               r_rst, r_enable, r_sx, r_sy, r_scale, r_id
    );

    modport slave (
        input  cmd_valid, cmd_sx, cmd_sy, cmd_id, cmd_scale, frame_start, r_finished,
        output cmd_ready, frame_done, busy, queue_count, timeout_err,
               r_rst, r_enable, r_sx, r_sy, r_scale, r_id
    );
endinterface
`default_nettype wire

// File: rtl/sprite_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sprite_draw_scheduler
// Brief    : Sprite command FIFO plus sequencer feeding one sprite at a time
//            to the renderer, with a per-sprite draw timeout.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_draw_scheduler #(
    parameter int CORDW   = 10,
    parameter int IDW     = 5,
    parameter int SCALEW  = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 65536
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sprite_draw_scheduler_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int DCW  = $clog2(TIMEOUT) + 1;
    localparam int EW   = 2*CORDW + IDW + SCALEW;

    localparam logic [CNTW-1:0] c_FULL     = CNTW'(DEPTH);
    localparam logic [DCW-1:0]  c_TMO_LAST = DCW'(TIMEOUT - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_DRAW  = 3'd2;
    localparam logic [2:0] c_NEXT  = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNTW-1:0]   r_count;
    logic [DCW-1:0]    r_dcnt;
    logic              r_timeout_err;
    logic [CORDW-1:0]  r_lat_sx;
    logic [CORDW-1:0]  r_lat_sy;
    logic [IDW-1:0]    r_lat_id;
    logic [SCALEW-1:0] r_lat_scale;

    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_timeout;
    logic [EW-1:0]     w_head;
    logic [CORDW-1:0]  w_head_sx;
    logic [CORDW-1:0]  w_head_sy;
    logic [IDW-1:0]    w_head_id;
    logic [SCALEW-1:0] w_head_scale;
    logic              w_busy;
    logic              w_done;
    logic              w_enable;

    assign w_ready   = (r_count != c_FULL);
    assign w_push    = bus.cmd_valid && w_ready;
    assign w_pop     = (r_state == c_FETCH);
    assign w_empty   = (r_count == '0);
    assign w_timeout = (r_state == c_DRAW) && !bus.r_finished && (r_dcnt == c_TMO_LAST);

    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_scale = w_head[SCALEW-1:0];
    assign w_head_id    = w_head[SCALEW +: IDW];
    assign w_head_sy    = w_head[SCALEW+IDW +: CORDW];
    assign w_head_sx    = w_head[SCALEW+IDW+CORDW +: CORDW];

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.cmd_sx, bus.cmd_sy, bus.cmd_id, bus.cmd_scale};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (bus.frame_start) w_next = w_empty ? c_DONE : c_FETCH;
            c_FETCH: w_next = (w_head_scale == '0) ? c_NEXT : c_DRAW;
            c_DRAW:  if (bus.r_finished || w_timeout) w_next = c_NEXT;
            c_NEXT:  w_next = w_empty ? c_DONE : c_FETCH;
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = 1'b1;
        w_done   = 1'b0;
        w_enable = 1'b0;
        case (r_state)
            c_IDLE:  w_busy   = 1'b0;
            c_DRAW:  w_enable = 1'b1;
            c_DONE:  w_done   = 1'b1;
            default: ;
        endcase
    end

    // Draw counter saturates so a stuck renderer can never wrap it back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dcnt        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == c_FETCH) begin
                r_dcnt <= '0;
            end else if ((r_state == c_DRAW) && (r_dcnt != {DCW{1'b1}})) begin
                r_dcnt <= r_dcnt + DCW'(1);
            end
            if (w_timeout) r_timeout_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_sx    <= '0;
            r_lat_sy    <= '0;
            r_lat_id    <= '0;
            r_lat_scale <= '0;
        end else if (r_state == c_FETCH) begin
            r_lat_sx    <= w_head_sx;
            r_lat_sy    <= w_head_sy;
            r_lat_id    <= w_head_id;
            r_lat_scale <= w_head_scale;
        end
    end

    assign bus.cmd_ready   = w_ready;
    assign bus.queue_count = r_count;
    assign bus.busy        = w_busy;
    assign bus.frame_done  = w_done;
    assign bus.timeout_err = r_timeout_err;
    assign bus.r_enable    = w_enable;
    assign bus.r_rst       = !w_enable;
    assign bus.r_sx        = r_lat_sx;
    assign bus.r_sy        = r_lat_sy;
    assign bus.r_id        = r_lat_id;
    assign bus.r_scale     = r_lat_scale;
endmodule
`default_nettype wire

// File: tb/tb_sprite_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_draw_scheduler
// Brief    : Directed self-checking bench for sprite_draw_scheduler with a
//            simple renderer model (finishes after 16 enabled cycles; id 31 hangs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_draw_scheduler;
    localparam int CORDW   = 10;
    localparam int IDW     = 5;
    localparam int SCALEW  = 8;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sprite_draw_scheduler_if #(.CORDW(CORDW), .IDW(IDW), .SCALEW(SCALEW), .DEPTH(DEPTH)) bus ();

    sprite_draw_scheduler #(
        .CORDW(CORDW), .IDW(IDW), .SCALEW(SCALEW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Renderer model: counts enabled cycles since r_rst dropped.
    int r_ren_cnt = 0;
    always_ff @(posedge clk) begin
        if (bus.r_rst)         r_ren_cnt <= 0;
        else if (bus.r_enable) r_ren_cnt <= r_ren_cnt + 1;
    end
    assign bus.r_finished = (bus.r_id != 5'd31) && (r_ren_cnt >= 15);

    // Monitor: records each enable run (length and sprite latched at its start).
    int          r_nruns    = 0;
    int          r_ndone    = 0;
    int          r_cur_len  = 0;
    logic        r_prev_en  = 1'b0;
    logic        r_rst_viol = 1'b0;
    int          r_run_len [64];
    logic [9:0]  r_run_sx  [64];
    logic [4:0]  r_run_id  [64];
    always @(negedge clk) begin
        r_prev_en <= bus.r_enable;
        if (bus.r_enable === 1'b1) begin
            if (!r_prev_en) begin
                r_cur_len <= 1;
                if (r_nruns < 64) begin
                    r_run_sx[r_nruns] <= bus.r_sx;
                    r_run_id[r_nruns] <= bus.r_id;
                end
            end else begin
                r_cur_len <= r_cur_len + 1;
            end
        end else if (r_prev_en) begin
            if (r_nruns < 64) r_run_len[r_nruns] <= r_cur_len;
            r_nruns <= r_nruns + 1;
        end
        if (bus.frame_done === 1'b1) r_ndone <= r_ndone + 1;
        if (bus.r_enable === bus.r_rst) r_rst_viol <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push(input int sx, input int sy, input int id, input int scale);
        bus.cmd_valid = 1'b1;
        bus.cmd_sx    = CORDW'(sx);
        bus.cmd_sy    = CORDW'(sy);
        bus.cmd_id    = IDW'(id);
        bus.cmd_scale = SCALEW'(scale);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) seen = 1'b1;
        end
        if (!seen) chk("wait_done", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base_runs;
        int base_done;

        bus.cmd_valid   = 1'b0;
        bus.cmd_sx      = '0;
        bus.cmd_sy      = '0;
        bus.cmd_id      = '0;
        bus.cmd_scale   = '0;
        bus.frame_start = 1'b0;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_count",   32'(bus.queue_count), 32'd0);
        chk("rst_ready",   32'(bus.cmd_ready),   32'd1);
        chk("rst_busy",    32'(bus.busy),        32'd0);
        chk("rst_done",    32'(bus.frame_done),  32'd0);
        chk("rst_tmo",     32'(bus.timeout_err), 32'd0);
        chk("rst_enable",  32'(bus.r_enable),    32'd0);
        chk("rst_r_rst",   32'(bus.r_rst),       32'd1);
        chk("rst_sx",      32'(bus.r_sx),        32'd0);

        // Single sprite
        push(100, 50, 3, 4);
        chk("t1_count", 32'(bus.queue_count), 32'd1);
        base_runs = r_nruns;
        base_done = r_ndone;
        frame();
        chk("t1_fetch_busy", 32'(bus.busy),     32'd1);
        chk("t1_fetch_en",   32'(bus.r_enable), 32'd0);
        @(negedge clk);
        chk("t1_draw_en", 32'(bus.r_enable), 32'd1);
        chk("t1_sx",      32'(bus.r_sx),     32'd100);
        chk("t1_sy",      32'(bus.r_sy),     32'd50);
        chk("t1_id",      32'(bus.r_id),     32'd3);
        chk("t1_scale",   32'(bus.r_scale),  32'd4);
        wait_done(200);
        chk("t1_runs",    32'(r_nruns - base_runs), 32'd1);
        chk("t1_len",     32'(r_run_len[base_runs]), 32'd16);
        chk("t1_ndone",   32'(r_ndone - base_done), 32'd1);
        chk("t1_busy",    32'(bus.busy),        32'd0);
        chk("t1_count0",  32'(bus.queue_count), 32'd0);
        chk("t1_hold_sx", 32'(bus.r_sx),        32'd100);

        // Empty frame
        base_runs = r_nruns;
        frame();
        chk("t2_done_now", 32'(bus.frame_done), 32'd1);
        @(negedge clk);
        chk("t2_done_off", 32'(bus.frame_done), 32'd0);
        chk("t2_busy",     32'(bus.busy),       32'd0);
        chk("t2_no_en",    32'(r_nruns - base_runs), 32'd0);

        // Fill to DEPTH, reject one more, drain in order
        for (int k = 0; k < 8; k++) push(10*k + 10, k, k, k + 1);
        chk("t3_full_cnt",   32'(bus.queue_count), 32'd8);
        chk("t3_full_ready", 32'(bus.cmd_ready),   32'd0);
        push(999, 9, 9, 9);
        chk("t3_reject", 32'(bus.queue_count), 32'd8);
        base_runs = r_nruns;
        base_done = r_ndone;
        frame();
        wait_done(1000);
        chk("t3_runs",  32'(r_nruns - base_runs), 32'd8);
        chk("t3_ndone", 32'(r_ndone - base_done), 32'd1);
        for (int k = 0; k < 8; k++) begin
            chk("t3_order_sx", 32'(r_run_sx[base_runs + k]), 32'(10*k + 10));
            chk("t3_order_id", 32'(r_run_id[base_runs + k]), 32'(k));
            chk("t3_len",      32'(r_run_len[base_runs + k]), 32'd16);
        end
        chk("t3_rst_between", 32'(r_rst_viol), 32'd0);

        // Zero-scale entry skipped
        push(1, 1, 1, 2);
        push(2, 2, 2, 0);
        push(3, 3, 3, 2);
        base_runs = r_nruns;
        base_done = r_ndone;
        frame();
        wait_done(200);
        chk("t4_runs",  32'(r_nruns - base_runs), 32'd2);
        chk("t4_sx0",   32'(r_run_sx[base_runs]),     32'd1);
        chk("t4_sx1",   32'(r_run_sx[base_runs + 1]), 32'd3);
        chk("t4_count", 32'(bus.queue_count), 32'd0);
        chk("t4_ndone", 32'(r_ndone - base_done), 32'd1);
        chk("t4_tmo",   32'(bus.timeout_err), 32'd0);

        // Hung renderer on id 31 times out; next sprite still drawn
        push(7, 7, 31, 5);
        push(8, 8, 4, 5);
        base_runs = r_nruns;
        base_done = r_ndone;
        frame();
        wait_done(300);
        chk("t5_runs",  32'(r_nruns - base_runs), 32'd2);
        chk("t5_len0",  32'(r_run_len[base_runs]),     32'd32);
        chk("t5_len1",  32'(r_run_len[base_runs + 1]), 32'd16);
        chk("t5_sx1",   32'(r_run_sx[base_runs + 1]),  32'd8);
        chk("t5_tmo",   32'(bus.timeout_err), 32'd1);
        chk("t5_ndone", 32'(r_ndone - base_done), 32'd1);

        // Reset in the middle of a draw with 3 still queued
        push(40, 0, 31, 1);
        push(41, 0, 1, 1);
        push(42, 0, 2, 1);
        push(43, 0, 3, 1);
        frame();
        repeat (6) @(negedge clk);
        chk("t6_pre_en",  32'(bus.r_enable),    32'd1);
        chk("t6_pre_cnt", 32'(bus.queue_count), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t6_en",    32'(bus.r_enable),    32'd0);
        chk("t6_r_rst", 32'(bus.r_rst),       32'd1);
        chk("t6_cnt",   32'(bus.queue_count), 32'd0);
        chk("t6_tmo",   32'(bus.timeout_err), 32'd0);
        chk("t6_busy",  32'(bus.busy),        32'd0);
        chk("t6_sx",    32'(bus.r_sx),        32'd0);
        chk("t6_ready", 32'(bus.cmd_ready),   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base_runs = r_nruns;
        frame();
        chk("t6_done_now", 32'(bus.frame_done), 32'd1);
        @(negedge clk);
        chk("t6_no_en", 32'(r_nruns - base_runs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
